// File: rtl/arm_alu_pkg.sv
// Shared types and constants for the LEGv8 execute-stage ALU:
// ALU operation encoding, main-decoder classes and instruction opcodes.
package arm_alu_pkg;

    typedef enum logic [2:0] {
        PASS_B = 3'b000,
        ADD    = 3'b010,
        SUB    = 3'b011,
        AND    = 3'b100,
        ORR    = 3'b101,
        EOR    = 3'b110
    } alu_cntrl_e;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;

    // Immediate forms carry one immediate bit in opcode[0], so they match on [10:1].
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;

endpackage

// File: rtl/arm_alu_pipe_reg.sv
// Synchronous-reset D register with load enable; used for the EX/MEM
// result register and the condition-flag register.
module pipe_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/arm_alu.sv
// Execute-stage ALU: decodes ALUOp/opcode, computes result and NZVC flags,
// and registers the result (every cycle) and flags (ADDS/SUBS only).
module arm_alu
    import arm_alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [WIDTH-1:0] result_q,
    output logic             n_q,
    output logic             z_q,
    output logic             v_q,
    output logic             c_q
);

    alu_cntrl_e       w_cntrl;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_carry_into_msb;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    logic             w_carry;
    logic             w_flag_en;
    logic [3:0]       w_flags_q;

    always_comb begin
        w_cntrl = ADD;
        case (alu_op)
            ALUOP_MEM: w_cntrl = ADD;
            ALUOP_CBZ: w_cntrl = PASS_B;
            ALUOP_RTYPE: begin
                case (opcode)
                    OP_ADD, OP_ADDS: w_cntrl = ADD;
                    OP_SUB, OP_SUBS: w_cntrl = SUB;
                    OP_AND:          w_cntrl = AND;
                    OP_ORR:          w_cntrl = ORR;
                    OP_EOR:          w_cntrl = EOR;
                    default:         w_cntrl = ADD;
                endcase
            end
            ALUOP_IMM: begin
                case (opcode[10:1])
                    OP_ADDI: w_cntrl = ADD;
                    OP_SUBI: w_cntrl = SUB;
                    default: w_cntrl = ADD;
                endcase
            end
            default: w_cntrl = ADD;
        endcase
    end

    // Subtraction is A + ~B + 1, so one adder serves both and carry means "no borrow".
    assign w_cin   = (w_cntrl == SUB);
    assign w_b_eff = w_cin ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    assign w_carry_into_msb = w_sum[WIDTH-1] ^ a[WIDTH-1] ^ w_b_eff[WIDTH-1];

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        w_carry    = 1'b0;
        case (w_cntrl)
            PASS_B: w_result = b;
            ADD, SUB: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = w_carry_into_msb ^ w_sum[WIDTH];
            end
            AND:     w_result = a & b;
            ORR:     w_result = a | b;
            EOR:     w_result = a ^ b;
            default: w_result = '0;
        endcase
    end

    assign cntrl     = w_cntrl;
    assign result    = w_result;
    assign negative  = w_result[WIDTH-1];
    assign zero      = (w_result == '0);
    assign overflow  = w_overflow;
    assign carry_out = w_carry;

    pipe_reg #(.WIDTH(WIDTH)) u_result_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (w_result),
        .q     (result_q)
    );

    // Flag register is keyed on the raw opcode: only ADDS/SUBS set condition codes.
    assign w_flag_en = (opcode == OP_ADDS) || (opcode == OP_SUBS);

    pipe_reg #(.WIDTH(4)) u_flag_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_flag_en),
        .d     ({negative, zero, overflow, carry_out}),
        .q     (w_flags_q)
    );

    assign n_q = w_flags_q[3];
    assign z_q = w_flags_q[2];
    assign v_q = w_flags_q[1];
    assign c_q = w_flags_q[0];

endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_arm_alu;

    localparam logic [1:0]  C_MEM = 2'b00, C_CBZ = 2'b01, C_RT = 2'b10, C_IMM = 2'b11;
    localparam logic [10:0] T_ADD  = 11'b10001011000, T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_ADDS = 11'b10101011000, T_SUBS = 11'b11101011000;
    localparam logic [10:0] T_AND  = 11'b10001010000, T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_EOR  = 11'b11001010000;
    localparam logic [10:0] T_ADDI = 11'b10010001001, T_SUBI = 11'b11010001000;
    localparam logic [10:0] T_LDUR = 11'b11111000010, T_CBZ  = 11'b10110100000;
    localparam logic [10:0] T_JUNK = 11'b11111111111;

    typedef struct packed {
        logic [63:0] r;
        logic        n, z, v, c;
    } alu_out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  alu_op = '0;
    logic [10:0] opcode = '0;
    logic [63:0] a = '0, b = '0;
    logic [2:0]  cntrl;
    logic [63:0] result, result_q;
    logic        negative, zero, overflow, carry_out, n_q, z_q, v_q, c_q;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    arm_alu #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .opcode(opcode), .a(a), .b(b),
        .cntrl(cntrl), .result(result), .negative(negative), .zero(zero),
        .overflow(overflow), .carry_out(carry_out), .result_q(result_q),
        .n_q(n_q), .z_q(z_q), .v_q(v_q), .c_q(c_q)
    );

    function automatic logic [2:0] m_cntrl(input logic [1:0] op, input logic [10:0] opc);
        if (op == C_MEM) return 3'b010;
        if (op == C_CBZ) return 3'b000;
        if (op == C_RT) begin
            if (opc == T_ADD || opc == T_ADDS) return 3'b010;
            if (opc == T_SUB || opc == T_SUBS) return 3'b011;
            if (opc == T_AND) return 3'b100;
            if (opc == T_ORR) return 3'b101;
            if (opc == T_EOR) return 3'b110;
            return 3'b010;
        end
        if (opc[10:1] == 10'b1101000100) return 3'b011;
        return 3'b010;
    endfunction

    // Overflow: the exact signed result does not fit in 64 signed bits.
    function automatic alu_out_t m_alu(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y);
        alu_out_t o;
        logic [64:0] u;
        logic signed [65:0] s;
        o = '0;
        s = '0;
        case (op)
            3'b000: o.r = y;
            3'b010: begin
                u = {1'b0, x} + {1'b0, y};
                o.r = u[63:0];
                o.c = u[64];
                s = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
                o.v = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
            end
            3'b011: begin
                o.r = x - y;
                o.c = (x >= y);
                s = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
                o.v = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
            end
            3'b100: o.r = x & y;
            3'b101: o.r = x | y;
            3'b110: o.r = x ^ y;
            default: o.r = '0;
        endcase
        o.n = o.r[63];
        o.z = (o.r == 64'd0);
        return o;
    endfunction

    alu_out_t    exp_now;
    logic [2:0]  exp_cntrl;
    logic [63:0] exp_q;
    logic [3:0]  exp_f;
    logic        m_valid = 1'b0;

    assign exp_cntrl = m_cntrl(alu_op, opcode);
    assign exp_now   = m_alu(exp_cntrl, a, b);

    always @(posedge clk) begin
        if (reset) begin
            exp_q   <= '0;
            exp_f   <= '0;
            m_valid <= 1'b1;
        end else begin
            exp_q <= exp_now.r;
            if (opcode == T_ADDS || opcode == T_SUBS)
                exp_f <= {exp_now.n, exp_now.z, exp_now.v, exp_now.c};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cntrl", {61'd0, cntrl}, {61'd0, exp_cntrl});
            chk("result", result, exp_now.r);
            chk("nzvc", {60'd0, negative, zero, overflow, carry_out},
                {60'd0, exp_now.n, exp_now.z, exp_now.v, exp_now.c});
            chk("result_q", result_q, exp_q);
            chk("flags_q", {60'd0, n_q, z_q, v_q, c_q}, {60'd0, exp_f});
            $display("cyc t=%0t op=%b opc=%b a=%h b=%h res=%h q=%h nzvc_q=%b%b%b%b",
                     $time, alu_op, opcode, a, b, result, result_q, n_q, z_q, v_q, c_q);
        end
    end

    task automatic step(input logic rst, input logic [1:0] op, input logic [10:0] opc,
                        input logic [63:0] av, input logic [63:0] bv);
        @(posedge clk);
        #1;
        reset = rst; alu_op = op; opcode = opc; a = av; b = bv;
        #2;
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [10:0] opc;
        logic [63:0] av, bv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{C_IMM, T_ADDI, 64'd100, 64'd23};
        vecs[1] = '{C_IMM, T_SUBI, 64'd5, 64'd9};
        vecs[2] = '{C_MEM, T_LDUR, 64'h1000, 64'd8};
        vecs[3] = '{C_RT,  T_JUNK, 64'd40, 64'd2};
        vecs[4] = '{C_RT,  T_SUBS, 64'd3, 64'd5};
        vecs[5] = '{C_RT,  T_SUBS, 64'h8000_0000_0000_0000, 64'd1};
        vecs[6] = '{C_RT,  T_ADDS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[7] = '{C_RT,  T_SUB,  64'd0, 64'd1};

        step(1'b1, C_RT, T_ADD, 64'd0, 64'd0);
        step(1'b1, C_RT, T_ADD, 64'd0, 64'd0);
        chk("reset result_q", result_q, 64'd0);
        chk("reset flags", {60'd0, n_q, z_q, v_q, c_q}, 64'd0);

        step(1'b0, C_RT, T_ADD, 64'd5, 64'd7);
        chk("add result", result, 64'd12);
        chk("add nzvc", {60'd0, negative, zero, overflow, carry_out}, 64'd0);
        chk("add cntrl", {61'd0, cntrl}, 64'd2);

        step(1'b0, C_RT, T_SUBS, 64'd3, 64'd3);
        chk("add result_q", result_q, 64'd12);
        chk("add flags held", {60'd0, n_q, z_q, v_q, c_q}, 64'd0);
        chk("subs result", result, 64'd0);
        chk("subs nzvc", {60'd0, negative, zero, overflow, carry_out}, 64'b0101);
        chk("subs cntrl", {61'd0, cntrl}, 64'd3);

        step(1'b0, C_RT, T_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("subs flags_q", {60'd0, n_q, z_q, v_q, c_q}, 64'b0101);
        chk("adds result", result, 64'h8000_0000_0000_0000);
        chk("adds nzvc", {60'd0, negative, zero, overflow, carry_out}, 64'b1010);

        step(1'b0, C_RT, T_AND, 64'hF0F0, 64'h0FF0);
        chk("adds flags_q", {60'd0, n_q, z_q, v_q, c_q}, 64'b1010);
        chk("and result", result, 64'h00F0);
        chk("and vc", {62'd0, overflow, carry_out}, 64'd0);
        step(1'b0, C_RT, T_ORR, 64'hF0F0, 64'h0FF0);
        chk("orr result", result, 64'hFFF0);
        step(1'b0, C_RT, T_EOR, 64'hF0F0, 64'h0FF0);
        chk("eor result", result, 64'hFF00);
        chk("eor vc", {62'd0, overflow, carry_out}, 64'd0);

        step(1'b0, C_CBZ, T_CBZ, 64'd77, 64'd0);
        chk("logic flags held", {60'd0, n_q, z_q, v_q, c_q}, 64'b1010);
        chk("cbz cntrl", {61'd0, cntrl}, 64'd0);
        chk("cbz zero", {63'd0, zero}, 64'd1);
        step(1'b0, C_CBZ, T_CBZ, 64'd77, 64'h10);
        chk("cbz nonzero", {63'd0, zero}, 64'd0);
        chk("cbz result", result, 64'h10);

        step(1'b0, C_RT, T_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step(1'b1, C_RT, T_SUB, 64'd10, 64'd3);
        chk("comb during reset", result, 64'd7);
        step(1'b0, C_RT, T_SUB, 64'd10, 64'd3);
        chk("mid reset result_q", result_q, 64'd0);
        chk("mid reset flags", {60'd0, n_q, z_q, v_q, c_q}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, vecs[i].op, vecs[i].opc, vecs[i].av, vecs[i].bv);
            if (i == 1) chk("subi result", result, 64'hFFFF_FFFF_FFFF_FFFC);
            if (i == 4) chk("subs borrow nzvc", {60'd0, negative, zero, overflow, carry_out}, 64'b1000);
            if (i == 6) chk("adds wrap nzvc", {60'd0, negative, zero, overflow, carry_out}, 64'b0101);
        end
        step(1'b0, C_RT, T_ADD, 64'd0, 64'd0);
        chk("last flags_q", {60'd0, n_q, z_q, v_q, c_q}, 64'b0101);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
